// File: rtl/imm_gen_if.sv
// Stream bundle for the pipelined immediate generator: instruction beats in,
// extended immediates out, plus the flush strobe that clears buffered beats.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      in_inst;
  logic [2:0]       in_imm_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, in_inst, in_imm_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_err, out_tag
  );

  modport slave (
    input  flush, in_valid, in_inst, in_imm_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_err, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: one-cycle extension into an output register
// backed by a single skid entry so in_ready never depends on out_ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  imm_gen_if.slave  bus
);

  localparam logic [2:0] SEL_I = 3'd0;
  localparam logic [2:0] SEL_S = 3'd1;
  localparam logic [2:0] SEL_B = 3'd2;
  localparam logic [2:0] SEL_U = 3'd3;
  localparam logic [2:0] SEL_J = 3'd4;
  localparam logic [2:0] SEL_Z = 3'd5;

  localparam logic [0:0] EMPTY_SKID = 1'b0;
  localparam logic [0:0] FULL_SKID  = 1'b1;

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // Every format fits in 32 signed bits; the final cast sign-extends to XLEN,
  // and Z is built non-negative so the same cast yields zero fill.
  function automatic logic signed [XLEN-1:0] extend(input logic [24:0] inst,
                                                     input logic [2:0]  sel);
    logic [31:7]        i;
    logic signed [31:0] v;
    i = inst;
    case (sel)
      SEL_I:   v = {{20{i[31]}}, i[31:20]};
      SEL_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
      SEL_B:   v = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      SEL_U:   v = {i[31:12], 12'b0};
      SEL_J:   v = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      SEL_Z:   v = {27'b0, i[19:15]};
      default: v = '0;
    endcase
    return XLEN'(v);
  endfunction

  function automatic logic illegal_sel(input logic [2:0] sel);
    return sel > SEL_Z;
  endfunction

  logic [0:0]             state;
  logic                   accept;
  logic                   out_free;
  logic                   load_skid;

  logic signed [XLEN-1:0] imm_p0;
  logic                   err_p0;
  logic [TAG_W-1:0]       tag_p0;

  logic                   vld_p1;
  logic [XLEN-1:0]        imm_p1;
  logic                   err_p1;
  logic [TAG_W-1:0]       tag_p1;

  logic [XLEN-1:0]        imm_sk_p1;
  logic                   err_sk_p1;
  logic [TAG_W-1:0]       tag_sk_p1;

  // ---- stage p0: combinational extension of the incoming beat ----
  assign imm_p0 = extend(bus.in_inst, bus.in_imm_sel);
  assign err_p0 = illegal_sel(bus.in_imm_sel);
  assign tag_p0 = bus.in_tag;

  assign bus.in_ready = (state == EMPTY_SKID);
  assign accept       = bus.in_valid && (state == EMPTY_SKID);
  assign out_free     = !vld_p1 || bus.out_ready;
  assign load_skid    = !bus.flush && accept && !out_free;

  // ---- stage p1: output register and skid state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY_SKID;
      vld_p1 <= 1'b0;
      imm_p1 <= '0;
      err_p1 <= 1'b0;
      tag_p1 <= '0;
    end else if (bus.flush) begin
      state  <= EMPTY_SKID;
      vld_p1 <= 1'b0;
    end else if (state == FULL_SKID) begin
      if (bus.out_ready) begin
        imm_p1 <= imm_sk_p1;
        err_p1 <= err_sk_p1;
        tag_p1 <= tag_sk_p1;
        state  <= EMPTY_SKID;
      end
    end else if (accept) begin
      if (out_free) begin
        vld_p1 <= 1'b1;
        imm_p1 <= imm_p0;
        err_p1 <= err_p0;
        tag_p1 <= tag_p0;
      end else begin
        state <= FULL_SKID;
      end
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Skid payload only matters while state says FULL_SKID, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      imm_sk_p1 <= imm_p0;
      err_sk_p1 <= err_p0;
      tag_sk_p1 <= tag_p0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_imm   = imm_p1;
  assign bus.out_err   = err_p1;
  assign bus.out_tag   = tag_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: identical beats drive an XLEN=32 and an
// XLEN=64 instance; monitors pop expected beats whenever an output transfers.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(32), .TAG_W(8)) b32 ();
  imm_gen_if #(.XLEN(64), .TAG_W(8)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  typedef struct {
    logic [63:0] imm;
    logic        err;
    logic [7:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  s;
    logic [63:0] e;
    logic        err;
  } vec_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  vec_t vecs[12];
  int   tests = 0;
  int   fails = 0;
  time  t0, t1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] s, input logic [7:0] tag);
    b32.in_valid = v;       b64.in_valid = v;
    b32.in_inst = w[31:7];  b64.in_inst = w[31:7];
    b32.in_imm_sel = s;     b64.in_imm_sel = s;
    b32.in_tag = tag;       b64.in_tag = tag;
  endtask

  task automatic set_ready(input logic r);
    b32.out_ready = r;
    b64.out_ready = r;
  endtask

  task automatic set_flush(input logic f);
    b32.flush = f;
    b64.flush = f;
  endtask

  // Present one beat, queue its expected result when it is about to be
  // accepted, and return one time step after the accepting edge.
  task automatic send(input logic [31:0] w, input logic [2:0] s, input logic [7:0] tag,
                      input logic [63:0] exp, input logic err);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    drive(1'b1, w, s, tag);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (b32.in_ready && b64.in_ready) begin
        e.imm = exp; e.err = err; e.tag = tag;
        q32.push_back(e);
        q64.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: tag %0d never accepted, expected acceptance within 100 cycles", tag);
    end
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 3'd0, 8'h0);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (q32.size() == 0 && q64.size() == 0 && !b32.out_valid && !b64.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", q32.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) begin
        tests++; fails++;
        $display("FAIL mon32_extra: got beat tag %0d, expected no beat", b32.out_tag);
      end else begin
        e32 = q32.pop_front();
        check("mon32_imm", 64'(b32.out_imm), {32'h0, e32.imm[31:0]});
        check("mon32_err", 64'(b32.out_err), 64'(e32.err));
        check("mon32_tag", 64'(b32.out_tag), 64'(e32.tag));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b64.out_valid && b64.out_ready) begin
      if (q64.size() == 0) begin
        tests++; fails++;
        $display("FAIL mon64_extra: got beat tag %0d, expected no beat", b64.out_tag);
      end else begin
        e64 = q64.pop_front();
        check("mon64_imm", b64.out_imm, e64.imm);
        check("mon64_err", 64'(b64.out_err), 64'(e64.err));
        check("mon64_tag", 64'(b64.out_tag), 64'(e64.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'hFFC48413, 3'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[1]  = '{32'hFE512C23, 3'd1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
    vecs[2]  = '{32'h00A12423, 3'd1, 64'h0000_0000_0000_0008, 1'b0};
    vecs[3]  = '{32'hFE000EE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[4]  = '{32'h123450B7, 3'd3, 64'h0000_0000_1234_5000, 1'b0};
    vecs[5]  = '{32'h001000EF, 3'd4, 64'h0000_0000_0000_0800, 1'b0};
    vecs[6]  = '{32'hFFFF8073, 3'd5, 64'h0000_0000_0000_001F, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 3'd6, 64'h0000_0000_0000_0000, 1'b1};
    vecs[8]  = '{32'h00C48413, 3'd0, 64'h0000_0000_0000_000C, 1'b0};
    vecs[9]  = '{32'h800000B7, 3'd3, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[10] = '{32'h800000EF, 3'd4, 64'hFFFF_FFFF_FFF0_0000, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 3'd7, 64'h0000_0000_0000_0000, 1'b1};

    drive(1'b0, 32'h0, 3'd0, 8'h0);
    set_ready(1'b1);
    set_flush(1'b0);
    rst = 1'b1;

    // Reset state
    #12;
    check("rst_valid", 64'(b32.out_valid), 64'd0);
    check("rst_imm32", 64'(b32.out_imm), 64'd0);
    check("rst_imm64", b64.out_imm, 64'd0);
    check("rst_err", 64'(b32.out_err), 64'd0);
    check("rst_tag", 64'(b32.out_tag), 64'd0);
    check("rst_in_ready", 64'(b32.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // One-cycle latency on the first beat
    send(32'h00C48413, 3'd0, 8'd1, 64'h0000_0000_0000_000C, 1'b0);
    check("lat_valid", 64'(b32.out_valid), 64'd1);
    check("lat_imm", 64'(b32.out_imm), 64'h0000_000C);
    check("lat_imm64", b64.out_imm, 64'h0000_0000_0000_000C);

    // Directed formats streamed back to back
    t0 = $time;
    for (int k = 0; k < 12; k++)
      send(vecs[k].w, vecs[k].s, 8'(k + 10), vecs[k].e, vecs[k].err);
    t1 = $time;
    check("throughput_cycles", 64'((t1 - t0) / 10), 64'd12);
    drain();

    // Backpressure: OUT and SKID fill, third beat waits, then streams out
    set_ready(1'b0);
    send(32'h00C48413, 3'd0, 8'd1, 64'h0000_0000_0000_000C, 1'b0);
    send(32'hFFC48413, 3'd0, 8'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    check("bp_in_ready_low", 64'(b32.in_ready), 64'd0);
    check("bp_out_tag", 64'(b32.out_tag), 64'd1);
    fork
      send(32'h001000EF, 3'd4, 8'd3, 64'h0000_0000_0000_0800, 1'b0);
      begin
        repeat (2) @(negedge clk);
        check("bp_hold_valid", 64'(b32.out_valid), 64'd1);
        check("bp_hold_tag", 64'(b32.out_tag), 64'd1);
        check("bp_hold_imm", 64'(b32.out_imm), 64'h0000_000C);
        check("bp_hold_in_ready", 64'(b32.in_ready), 64'd0);
        @(posedge clk); #1;
        set_ready(1'b1);
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          check("bp_stream_valid", 64'(b32.out_valid), 64'd1);
          check("bp_stream_tag", 64'(b32.out_tag), 64'(k));
        end
      end
    join
    drain();

    // Flush with OUT and SKID full, plus a beat offered in the flush cycle
    set_ready(1'b0);
    send(32'h123450B7, 3'd3, 8'd20, 64'h0000_0000_1234_5000, 1'b0);
    send(32'hFE512C23, 3'd1, 8'd21, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    drive(1'b1, 32'h001000EF, 3'd4, 8'd22);
    set_flush(1'b1);
    q32.delete();
    q64.delete();
    @(posedge clk); #1;
    set_flush(1'b0);
    drive(1'b0, 32'h0, 3'd0, 8'h0);
    check("flush_valid", 64'(b32.out_valid), 64'd0);
    check("flush_valid64", 64'(b64.out_valid), 64'd0);
    check("flush_in_ready", 64'(b32.in_ready), 64'd1);
    @(posedge clk); #1;
    check("flush_no_stale", 64'(b32.out_valid), 64'd0);
    set_ready(1'b1);
    send(32'hFE000EE3, 3'd2, 8'd23, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    drain();

    // Beat offered while flushing with in_ready high is dropped
    drive(1'b1, 32'h00C48413, 3'd0, 8'd24);
    set_flush(1'b1);
    @(posedge clk); #1;
    set_flush(1'b0);
    drive(1'b0, 32'h0, 3'd0, 8'h0);
    check("flush_drop_valid", 64'(b32.out_valid), 64'd0);

    // Asynchronous reset in the middle of a full pipeline
    set_ready(1'b0);
    send(32'hFFC48413, 3'd0, 8'd30, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'h001000EF, 3'd4, 8'd31, 64'h0000_0000_0000_0800, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(b32.out_valid), 64'd0);
    check("arst_imm32", 64'(b32.out_imm), 64'd0);
    check("arst_imm64", b64.out_imm, 64'd0);
    check("arst_tag", 64'(b32.out_tag), 64'd0);
    check("arst_in_ready", 64'(b32.in_ready), 64'd1);
    q32.delete();
    q64.delete();
    @(negedge clk);
    rst = 1'b0;
    set_ready(1'b1);
    @(posedge clk); #1;
    send(32'h800000B7, 3'd3, 8'd32, 64'hFFFF_FFFF_8000_0000, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator in the RV decode path. It accepts instruction words with an immediate-format select and an opaque tag through a valid/ready handshake. It sign- or zero-extends the immediate to XLEN and returns it, with the tag, through a registered output stage backed by a skid buffer. It adds the CSR zero-extended (Z) format, illegal-select flagging, flush, and full-throughput backpressure.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
TAG_W, 8, width of the sideband tag (PC slice, ROB id) carried unchanged alongside the immediate.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous; drops all buffered entries.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat.
in_inst  in  25  instruction bits [31:7].
in_imm_sel  in  3  format select: I=0, S=1, B=2, U=3, J=4, Z=5; 6 and 7 are illegal (`I_TYPE etc. in imm_sel.vh).
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  output beat valid.
out_ready  in  1  consumer accepts the beat.
out_imm  out  XLEN  extended immediate.
out_err  out  1  beat carried an illegal select.
out_tag  out  TAG_W  tag of the beat.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_imm=0, out_err=0, out_tag=0, skid buffer empty, in_ready=1.
- Input transfer happens when in_valid&&in_ready. Output transfer happens when out_valid&&out_ready.
- Extension uses i = {in_inst, 7'b0} and sign s = i[31] replicated to XLEN:
  - I = s : i[31:20].
  - S = s : i[31:25], i[11:7].
  - B = s : i[31], i[7], i[30:25], i[11:8], 0.
  - U = s (XLEN=64 only) : i[31:12], 12'b0.
  - J = s : i[31], i[19:12], i[20], i[30:21], 0.
  - Z = zero-extended i[19:15].
  - Illegal select: imm=0, err=1. err=0 for all legal selects.
- Latency: 1 cycle. A beat accepted at edge N is on out_* after edge N, provided the output register is empty or draining.
- Storage: output register (OUT) plus one skid entry (SKID). Two states:
  - EMPTY_SKID: in_ready=1.
  - FULL_SKID: in_ready=0.
  - in_ready is driven from a register, never combinationally from out_ready.
- Per cycle, with no flush:
  - OUT empty or draining, SKID empty: an accepted beat loads OUT.
  - OUT valid and not draining: an accepted beat loads SKID and the state goes to FULL_SKID.
  - FULL_SKID and draining: SKID moves to OUT, SKID is cleared, and the state goes to EMPTY_SKID. No input is accepted that cycle.
- Ordering: beats leave strictly in acceptance order. No beat is duplicated or dropped except by flush or reset.
- Output stability: while out_valid=1 and out_ready=0, out_imm, out_err and out_tag are held stable.
- Flush: at the next edge out_valid=0, SKID is cleared and in_ready=1. A beat presented in the flush cycle is discarded. Flush wins over every simultaneous event.
- Reset mid-operation: all contents are lost immediately; no partial beat is emitted.
- Throughput: with out_ready held at 1, the block sustains 1 beat/cycle.
- Unused: out_imm bits above the format width are always pure sign or zero fill.

Test Plan:
- XLEN=32, I format:
  - 0x00C48413 → out_imm=0x0000000C, err=0, one cycle after accept.
  - 0xFFC48413 → 0xFFFFFFFC.
- S, B, U, J formats:
  - 0xFE512C23 (S) → 0xFFFFFFF8.
  - 0xFE000EE3 (B) → 0xFFFFFFFC.
  - 0x123450B7 (U) → 0x12345000.
  - 0x001000EF (J) → 0x00000800.
- Z and illegal selects:
  - Z with inst[19:15]=5'b11111 → 0x0000001F.
  - sel=6 → imm=0, err=1.
  - The following legal beat → err=0.
- XLEN=64:
  - 0xFFC48413 (I) → 0xFFFFFFFFFFFFFFFC.
  - 0x800000B7 (U) → 0xFFFFFFFF80000000.
- Backpressure:
  - Hold out_ready=0 and push tags 1, 2, 3.
  - in_ready drops after tag 2 is accepted; tag 3 is held with out_* stable.
  - Raise out_ready: tags emerge 1, 2, 3 on consecutive beats, with no bubble once streaming.
- Flush and reset:
  - With OUT and SKID full, assert flush for one cycle → out_valid=0 and in_ready=1 next cycle; a new beat passes normally.
  - Assert rst mid-stream → outputs zero immediately.
